fare_settlement: RTL and testbench

- Downstream of the taxi meter. Watches each fare source (seats 0-3 and the VIP fare) for the end of a ride and captures that source's final cost.
- Queues one receipt per finished ride and drains receipts to the display/printer over a valid/ready handshake.
- Keeps a running settled total and a receipt count for the shift.

---
 rtl/taxi_pkg.sv | 19 +
 rtl/receipt_fifo.sv | 66 ++++++
 rtl/fare_settlement.sv | 174 +++++++++++++++++
 tb/tb_fare_settlement.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/taxi_pkg.sv
// Shared fare-settlement definitions: meter cost width, fare source encodings
// and the packed receipt record carried through the receipt FIFO.
package taxi_pkg;

  localparam int COST_W  = 14;
  localparam int NUM_SRC = 5;

  localparam logic [2:0] SRC_SEAT0 = 3'd0;
  localparam logic [2:0] SRC_SEAT1 = 3'd1;
  localparam logic [2:0] SRC_SEAT2 = 3'd2;
  localparam logic [2:0] SRC_SEAT3 = 3'd3;
  localparam logic [2:0] SRC_VIP   = 3'd4;

  typedef struct packed {
    logic [2:0]        source;
    logic [COST_W-1:0] amount;
  } receipt_t;

endpackage

// File: rtl/receipt_fifo.sv
// Small circular receipt FIFO; the head is zeroed while empty so the
// downstream data lines read 0 whenever nothing is queued.
module receipt_fifo
  import taxi_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = receipt_t
) (
  input  logic                   clock_i,
  input  logic                   reset_n_i,
  input  logic                   push_i,
  input  T                       push_data_i,
  input  logic                   pop_i,
  output T                       head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign do_pop  = pop_i && !empty_o;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/fare_settlement.sv
// Captures the final fare of each finished ride (seats 0-3, VIP), queues one
// receipt per ride for the display/printer and keeps the shift totals.
module fare_settlement
  import taxi_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TOTAL_W = 16
) (
  input  logic               clock_i,
  input  logic               reset_n_i,
  input  logic               seat_0_i,
  input  logic               seat_1_i,
  input  logic               seat_2_i,
  input  logic               seat_3_i,
  input  logic               vip_enable_i,
  input  logic [COST_W-1:0]  s0cost_i,
  input  logic [COST_W-1:0]  s1cost_i,
  input  logic [COST_W-1:0]  s2cost_i,
  input  logic [COST_W-1:0]  s3cost_i,
  input  logic [COST_W-1:0]  vip_cost_i,
  output logic               receipt_valid_o,
  input  logic               receipt_ready_i,
  output logic [2:0]         receipt_source_o,
  output logic [COST_W-1:0]  receipt_amount_o,
  output logic [TOTAL_W-1:0] settled_total_o,
  output logic [7:0]         receipt_count_o,
  output logic               overrun_o
);

  logic [3:0]         seat_now;
  logic [COST_W-1:0]  cost_now [NUM_SRC];
  logic [3:0]         seat_q;
  logic               vip_q;
  logic [NUM_SRC-1:0] event_w;

  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [COST_W-1:0]  amt_q [NUM_SRC];
  logic [COST_W-1:0]  amt_d [NUM_SRC];
  logic               ovr_q, ovr_d;

  logic [NUM_SRC-1:0] grant_oh;
  logic [2:0]         grant_src;
  logic               push;
  logic               pop;
  receipt_t           push_data;
  receipt_t           head;
  logic               fifo_full;
  logic               fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;

  logic [TOTAL_W-1:0] total_q, total_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [TOTAL_W:0]   sum_w;

  assign seat_now    = {seat_3_i, seat_2_i, seat_1_i, seat_0_i};
  assign cost_now[0] = s0cost_i;
  assign cost_now[1] = s1cost_i;
  assign cost_now[2] = s2cost_i;
  assign cost_now[3] = s3cost_i;
  assign cost_now[4] = vip_cost_i;

  // Edge-detect copies load unconditionally, including under reset, so a ride
  // in progress across reset never looks like a fresh falling edge.
  always_ff @(posedge clock_i) begin
    seat_q <= seat_now;
    vip_q  <= vip_enable_i;
  end

  always_comb begin
    event_w = '0;
    for (int i = 0; i < 4; i++) begin
      event_w[i] = seat_q[i] && !seat_now[i] && !vip_enable_i && !vip_q &&
                   (cost_now[i] != '0);
    end
    event_w[SRC_VIP] = vip_q && !vip_enable_i && (cost_now[SRC_VIP] != '0);
  end

  assign pop = !fifo_empty && receipt_ready_i;

  // VIP first, then seat 0..3; the downward scan lets the lowest seat win.
  always_comb begin
    grant_oh  = '0;
    grant_src = SRC_VIP;
    if (!fifo_full || pop) begin
      if (pend_q[SRC_VIP]) begin
        grant_oh[SRC_VIP] = 1'b1;
      end else begin
        for (int i = 3; i >= 0; i--) begin
          if (pend_q[i]) begin
            grant_oh    = '0;
            grant_oh[i] = 1'b1;
            grant_src   = 3'(i);
          end
        end
      end
    end
  end

  assign push      = |grant_oh;
  assign push_data = '{source: grant_src, amount: amt_q[grant_src]};

  always_comb begin
    pend_d = pend_q;
    amt_d  = amt_q;
    ovr_d  = ovr_q;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (grant_oh[s]) pend_d[s] = 1'b0;
      if (event_w[s]) begin
        if (pend_q[s] && !grant_oh[s]) begin
          ovr_d = 1'b1;
        end else begin
          pend_d[s] = 1'b1;
          amt_d[s]  = cost_now[s];
        end
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      pend_q <= '0;
      amt_q  <= '{default: '0};
      ovr_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      amt_q  <= amt_d;
      ovr_q  <= ovr_d;
    end
  end

  receipt_fifo #(
    .DEPTH (DEPTH),
    .T     (receipt_t)
  ) u_fifo (
    .clock_i     (clock_i),
    .reset_n_i   (reset_n_i),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign sum_w = {1'b0, total_q} + {{(TOTAL_W+1-COST_W){1'b0}}, head.amount};

  always_comb begin
    total_d = total_q;
    cnt_d   = cnt_q;
    if (pop) begin
      total_d = sum_w[TOTAL_W] ? '1 : sum_w[TOTAL_W-1:0];
      cnt_d   = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      total_q <= '0;
      cnt_q   <= '0;
    end else begin
      total_q <= total_d;
      cnt_q   <= cnt_d;
    end
  end

  assign receipt_valid_o  = (fifo_count != '0);
  assign receipt_source_o = head.source;
  assign receipt_amount_o = head.amount;
  assign settled_total_o  = total_q;
  assign receipt_count_o  = cnt_q;
  assign overrun_o        = ovr_q;

endmodule

// File: tb/tb_fare_settlement.sv
// Bench for fare_settlement: table vectors, directed ride sequences and a
// randomized run, all checked against a queue-based ride/receipt model.
module tb_fare_settlement;
  import taxi_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TOTAL_W = 16;
  localparam int TOT_MAX = (1 << TOTAL_W) - 1;

  logic               clock = 1'b0;
  logic               reset_n;
  logic [3:0]         seat;
  logic               vip;
  logic [COST_W-1:0]  scost [4];
  logic [COST_W-1:0]  vip_cost;
  logic               receipt_ready;
  logic               receipt_valid;
  logic [2:0]         receipt_source;
  logic [COST_W-1:0]  receipt_amount;
  logic [TOTAL_W-1:0] settled_total;
  logic [7:0]         receipt_count;
  logic               overrun;

  always #5 clock = ~clock;

  fare_settlement #(.DEPTH(DEPTH), .TOTAL_W(TOTAL_W)) dut (
    .clock_i          (clock),
    .reset_n_i        (reset_n),
    .seat_0_i         (seat[0]),
    .seat_1_i         (seat[1]),
    .seat_2_i         (seat[2]),
    .seat_3_i         (seat[3]),
    .vip_enable_i     (vip),
    .s0cost_i         (scost[0]),
    .s1cost_i         (scost[1]),
    .s2cost_i         (scost[2]),
    .s3cost_i         (scost[3]),
    .vip_cost_i       (vip_cost),
    .receipt_valid_o  (receipt_valid),
    .receipt_ready_i  (receipt_ready),
    .receipt_source_o (receipt_source),
    .receipt_amount_o (receipt_amount),
    .settled_total_o  (settled_total),
    .receipt_count_o  (receipt_count),
    .overrun_o        (overrun)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(string name, longint act, longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference model: rides end, fares wait per source, receipts queue up.
  typedef struct { int src; int amt; } rc_t;
  rc_t  m_q[$];
  bit   m_pend [5];
  int   m_amt [5];
  bit   m_prev_seat [4];
  bit   m_prev_vip;
  int   m_total, m_cnt;
  bit   m_ovr;

  task automatic model_edge();
    int order [5] = '{4, 0, 1, 2, 3};
    int g = -1;
    bit popping, can_push, ended;
    int cost;
    if (!reset_n) begin
      m_q.delete();
      foreach (m_pend[s]) m_pend[s] = 0;
      m_total = 0;
      m_cnt   = 0;
      m_ovr   = 0;
    end else begin
      popping  = (m_q.size() > 0) && receipt_ready;
      can_push = (m_q.size() < DEPTH) || popping;
      if (can_push)
        for (int k = 0; k < 5; k++)
          if (g < 0 && m_pend[order[k]]) g = order[k];
      if (popping) begin
        m_total = m_total + m_q[0].amt;
        if (m_total > TOT_MAX) m_total = TOT_MAX;
        m_cnt = (m_cnt + 1) % 256;
        void'(m_q.pop_front());
      end
      if (g >= 0) begin
        m_q.push_back('{g, m_amt[g]});
        m_pend[g] = 0;
      end
      for (int s = 0; s < 5; s++) begin
        if (s < 4) begin
          ended = m_prev_seat[s] && !seat[s] && !vip && !m_prev_vip;
          cost  = int'(scost[s]);
        end else begin
          ended = m_prev_vip && !vip;
          cost  = int'(vip_cost);
        end
        if (ended && cost != 0) begin
          if (m_pend[s]) m_ovr = 1;
          else begin
            m_pend[s] = 1;
            m_amt[s]  = cost;
          end
        end
      end
    end
    for (int s = 0; s < 4; s++) m_prev_seat[s] = seat[s];
    m_prev_vip = vip;
  endtask

  task automatic compare_model(string tag);
    int es = 0, ea = 0;
    if (m_q.size() > 0) begin
      es = m_q[0].src;
      ea = m_q[0].amt;
    end
    check({tag, "_valid"},  receipt_valid, (m_q.size() > 0) ? 1 : 0);
    check({tag, "_source"}, receipt_source, es);
    check({tag, "_amount"}, receipt_amount, ea);
    check({tag, "_total"},  settled_total, m_total);
    check({tag, "_count"},  receipt_count, m_cnt);
    check({tag, "_overrun"}, overrun, m_ovr);
  endtask

  task automatic cycle(string tag = "seq");
    model_edge();
    @(posedge clock);
    #1;
    compare_model(tag);
  endtask

  task automatic clear_costs();
    for (int i = 0; i < 4; i++) scost[i] = '0;
    vip_cost = '0;
  endtask

  task automatic do_reset();
    reset_n = 0;
    seat = '0;
    vip = 0;
    receipt_ready = 0;
    clear_costs();
    cycle("rst");
    cycle("rst");
    reset_n = 1;
  endtask

  task automatic seat_ride(int i, int cost);
    seat[i] = 1'b1;
    cycle();
    seat[i] = 1'b0;
    scost[i] = COST_W'(cost);
    cycle();
    clear_costs();
  endtask

  task automatic vip_ride(int cost);
    vip = 1;
    cycle();
    vip = 0;
    vip_cost = COST_W'(cost);
    cycle();
    clear_costs();
  endtask

  rc_t exp_q[$];

  task automatic expect_drain(string name);
    int got = 0;
    int budget = 60;
    receipt_ready = 1;
    while (got < exp_q.size() && budget > 0) begin
      if (receipt_valid) begin
        check($sformatf("%s_src%0d", name, got), receipt_source, exp_q[got].src);
        check($sformatf("%s_amt%0d", name, got), receipt_amount, exp_q[got].amt);
        got++;
      end
      cycle();
      budget--;
    end
    check({name, "_delivered"}, got, exp_q.size());
    receipt_ready = 0;
  endtask

  typedef struct {
    bit       rst_n;
    bit [3:0] seats;
    bit       vip;
    int       cost;
    bit       rdy;
    bit       ev;
    int       es, ea, et, en;
    bit       eo;
  } vec_t;

  vec_t tbl [22];

  initial begin
    reset_n = 0;
    seat = '0;
    vip = 0;
    receipt_ready = 0;
    clear_costs();

    //            rst seats   vip cost rdy | v src amt total cnt ovr
    tbl[0]  = '{0, 4'b0000, 0, 0,  0,   0, 0, 0,  0,  0, 0};
    tbl[1]  = '{1, 4'b0100, 0, 10, 0,   0, 0, 0,  0,  0, 0};
    tbl[2]  = '{1, 4'b0100, 0, 35, 0,   0, 0, 0,  0,  0, 0};
    tbl[3]  = '{1, 4'b0000, 0, 35, 0,   0, 0, 0,  0,  0, 0};
    tbl[4]  = '{1, 4'b0000, 0, 35, 0,   1, 2, 35, 0,  0, 0};
    tbl[5]  = '{1, 4'b0000, 0, 0,  1,   0, 0, 0,  35, 1, 0};
    tbl[6]  = '{1, 4'b0001, 0, 7,  0,   0, 0, 0,  35, 1, 0};
    tbl[7]  = '{1, 4'b0000, 0, 0,  0,   0, 0, 0,  35, 1, 0};
    tbl[8]  = '{1, 4'b0000, 0, 0,  0,   0, 0, 0,  35, 1, 0};
    tbl[9]  = '{1, 4'b0010, 0, 5,  0,   0, 0, 0,  35, 1, 0};
    tbl[10] = '{1, 4'b0000, 1, 5,  0,   0, 0, 0,  35, 1, 0};
    tbl[11] = '{1, 4'b0000, 1, 26, 0,   0, 0, 0,  35, 1, 0};
    tbl[12] = '{1, 4'b0000, 0, 26, 0,   0, 0, 0,  35, 1, 0};
    tbl[13] = '{1, 4'b0000, 0, 0,  0,   1, 4, 26, 35, 1, 0};
    tbl[14] = '{1, 4'b0000, 0, 0,  1,   0, 0, 0,  61, 2, 0};
    tbl[15] = '{1, 4'b1000, 0, 9,  0,   0, 0, 0,  61, 2, 0};
    tbl[16] = '{1, 4'b0000, 0, 9,  0,   0, 0, 0,  61, 2, 0};
    tbl[17] = '{1, 4'b1000, 0, 9,  0,   1, 3, 9,  61, 2, 0};
    tbl[18] = '{0, 4'b1000, 0, 9,  0,   0, 0, 0,  0,  0, 0};
    tbl[19] = '{1, 4'b1000, 0, 9,  0,   0, 0, 0,  0,  0, 0};
    tbl[20] = '{1, 4'b1000, 0, 9,  0,   0, 0, 0,  0,  0, 0};
    tbl[21] = '{1, 4'b0000, 0, 0,  0,   0, 0, 0,  0,  0, 0};

    for (int r = 0; r < 22; r++) begin
      string tag;
      tag = $sformatf("row%0d", r);
      reset_n = tbl[r].rst_n;
      seat = tbl[r].seats;
      vip = tbl[r].vip;
      for (int i = 0; i < 4; i++) scost[i] = COST_W'(tbl[r].cost);
      vip_cost = COST_W'(tbl[r].cost);
      receipt_ready = tbl[r].rdy;
      cycle(tag);
      check({tag, "_tv"}, receipt_valid, tbl[r].ev);
      check({tag, "_ts"}, receipt_source, tbl[r].es);
      check({tag, "_ta"}, receipt_amount, tbl[r].ea);
      check({tag, "_tt"}, settled_total, tbl[r].et);
      check({tag, "_tn"}, receipt_count, tbl[r].en);
      check({tag, "_to"}, overrun, tbl[r].eo);
    end

    // VIP ends one cycle before seats 1 and 3 end together.
    do_reset();
    seat = 4'b1010;
    vip = 1;
    cycle();
    vip_cost = 42;
    cycle();
    vip = 0;
    cycle();
    seat = 4'b0000;
    vip_cost = 0;
    scost[1] = 23;
    scost[3] = 31;
    cycle();
    clear_costs();
    exp_q = '{'{4, 42}, '{1, 23}, '{3, 31}};
    expect_drain("prio");
    check("prio_total", settled_total, 96);

    // Six rides against a 4-deep FIFO with the consumer stalled.
    do_reset();
    for (int i = 0; i < 4; i++) seat_ride(i, 10 + i);
    vip_ride(50);
    seat_ride(0, 60);
    cycle();
    check("fill_valid", receipt_valid, 1);
    check("fill_overrun", overrun, 0);
    exp_q = '{'{0, 10}, '{1, 11}, '{2, 12}, '{3, 13}, '{4, 50}, '{0, 60}};
    expect_drain("fill");
    check("fill_count", receipt_count, 6);
    check("fill_overrun_end", overrun, 0);

    // Second seat-0 ride while the first is still held behind a full FIFO.
    do_reset();
    seat_ride(1, 21);
    seat_ride(2, 22);
    seat_ride(3, 23);
    vip_ride(24);
    seat_ride(0, 70);
    seat_ride(0, 80);
    cycle();
    check("ovr_set", overrun, 1);
    exp_q = '{'{1, 21}, '{2, 22}, '{3, 23}, '{4, 24}, '{0, 70}};
    expect_drain("ovr");
    cycle();
    check("ovr_empty", receipt_valid, 0);
    check("ovr_sticky", overrun, 1);

    // Saturation: 4 x 16383 = 65532, then +10 clips at 65535.
    do_reset();
    receipt_ready = 1;
    for (int i = 0; i < 4; i++) seat_ride(i, 16383);
    cycle();
    cycle();
    check("sat_pre", settled_total, 65532);
    seat_ride(0, 10);
    for (int k = 0; k < 4; k++) cycle();
    check("sat_total", settled_total, 65535);
    check("sat_count", receipt_count, 5);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      reset_n = ($urandom_range(0, 599) != 0);
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 5) == 0) seat[i] = ~seat[i];
        scost[i] = ($urandom_range(0, 7) == 0) ? '0 : COST_W'($urandom_range(1, 16383));
      end
      if ($urandom_range(0, 19) == 0) vip = ~vip;
      vip_cost = ($urandom_range(0, 7) == 0) ? '0 : COST_W'($urandom_range(1, 16383));
      receipt_ready = ((c % 200) < 40) ? 1'b0 : ($urandom_range(0, 3) != 0);
      cycle("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
